// File: rtl/otter_mem_pkg.sv
// Shared types and encodings for the memory-access stage.
package otter_mem_pkg;

  typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} mem_state_t;
  typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2} mem_size_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RF_SEL_PC4 = 2'd0;
  localparam logic [1:0] RF_SEL_CSR = 2'd1;
  localparam logic [1:0] RF_SEL_MEM = 2'd2;
  localparam logic [1:0] RF_SEL_ALU = 2'd3;

  // Unknown funct3 codes fall back to word accesses.
  function automatic mem_size_t decode_size(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: decode_size = SZ_BYTE;
      F3_H, F3_HU: decode_size = SZ_HALF;
      default:     decode_size = SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (decode_size(funct3))
      SZ_HALF: is_misaligned = addr_lo[0];
      SZ_WORD: is_misaligned = (addr_lo != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Byte-lane enables, store-data replication and load extraction/extension.
module load_store_align
  import otter_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rs2,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Store side: lane enables and replicated data.
  always_comb begin
    be    = 4'b1111;
    wdata = rs2;
    case (decode_size(funct3))
      SZ_BYTE: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{rs2[7:0]}};
      end
      SZ_HALF: begin
        if (addr_lo[1]) be = 4'b1100;
        else            be = 4'b0011;
        wdata = {2{rs2[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = rs2;
      end
    endcase
  end

  // Load side: pick the addressed lane, then sign- or zero-extend.
  always_comb begin
    byte_s    = 8'd0;
    half_s    = 16'd0;
    load_data = rdata;
    case (addr_lo)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      2'd3:    byte_s = rdata[31:24];
      default: byte_s = 8'd0;
    endcase
    if (addr_lo[1]) half_s = rdata[31:16];
    else            half_s = rdata[15:0];
    case (funct3)
      F3_B:    load_data = {{24{byte_s[7]}}, byte_s};
      F3_BU:   load_data = {24'd0, byte_s};
      F3_H:    load_data = {{16{half_s[15]}}, half_s};
      F3_HU:   load_data = {16'd0, half_s};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// Memory-access pipeline stage: drives the req/ack data port, stalls upstream
// during an access and fills the MEM/WB register.
module memory_access_stage
  import otter_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        MEMORY_CLOCK,
  input  logic        MEMORY_RESET_N,
  input  logic        EXEC_VALID,
  input  logic [31:0] EXEC_PC_4,
  input  logic [31:0] EXEC_ALU_RESULT,
  input  logic [31:0] EXEC_RS2,
  input  logic [2:0]  EXEC_FUNCT3,
  input  logic [1:0]  EXEC_RF_WR_SEL,
  input  logic        EXEC_REGWRITE,
  input  logic        EXEC_MEMWRITE,
  input  logic        EXEC_MEMREAD2,
  input  logic [4:0]  EX_MS_RD,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  output logic [31:0] DMEM_ADDR,
  output logic [31:0] DMEM_WDATA,
  output logic [3:0]  DMEM_BE,
  input  logic        DMEM_ACK,
  input  logic [31:0] DMEM_RDATA,
  output logic        MEM_STALL,
  output logic        MEM_WB_VALID,
  output logic [31:0] MEM_WB_PC_4,
  output logic [31:0] MEM_WB_ALU_RESULT,
  output logic [31:0] MEM_WB_LOAD_DATA,
  output logic [1:0]  MEM_WB_RF_WR_SEL,
  output logic        MEM_WB_REGWRITE,
  output logic [4:0]  MEM_WB_RD,
  output logic        MISALIGN_ERR,
  output logic        BUS_ERR
);

  localparam logic [7:0] CNT_LIMIT = 8'(TIMEOUT_CYCLES - 1);

  mem_state_t  state_r, state_s;
  logic [7:0]  cnt_r, cnt_s;
  logic [2:0]  f3_r, f3_s;
  logic        req_r, req_s, we_r, we_s;
  logic [31:0] addr_r, addr_s, wdata_r, wdata_s;
  logic [3:0]  be_r, be_s;
  logic        wb_valid_r, wb_valid_s, wb_regwrite_r, wb_regwrite_s;
  logic [31:0] wb_pc_4_r, wb_pc_4_s, wb_alu_r, wb_alu_s, wb_load_r, wb_load_s;
  logic [1:0]  wb_sel_r, wb_sel_s;
  logic [4:0]  wb_rd_r, wb_rd_s;
  logic        misalign_r, misalign_s, bus_err_r, bus_err_s, stall_s;

  logic        memop_s, misaligned_s;
  logic [2:0]  align_f3_s;
  logic [1:0]  align_addr_s;
  logic [3:0]  align_be_s;
  logic [31:0] align_wdata_s, align_load_s;

  assign memop_s      = EXEC_VALID & (EXEC_MEMWRITE | EXEC_MEMREAD2);
  assign misaligned_s = is_misaligned(EXEC_FUNCT3, EXEC_ALU_RESULT[1:0]);
  // During ACCESS the extraction follows the issued request, not the live inputs.
  assign align_f3_s   = (state_r == ACCESS) ? f3_r : EXEC_FUNCT3;
  assign align_addr_s = (state_r == ACCESS) ? addr_r[1:0] : EXEC_ALU_RESULT[1:0];

  load_store_align u_align (
    .funct3    (align_f3_s),
    .addr_lo   (align_addr_s),
    .rs2       (EXEC_RS2),
    .rdata     (DMEM_RDATA),
    .be        (align_be_s),
    .wdata     (align_wdata_s),
    .load_data (align_load_s)
  );

  // Next-state, request and MEM/WB capture decisions.
  always_comb begin
    state_s = state_r;  cnt_s = cnt_r;  f3_s = f3_r;
    req_s = req_r;  we_s = we_r;  addr_s = addr_r;  wdata_s = wdata_r;  be_s = be_r;
    wb_valid_s = 1'b0;  wb_regwrite_s = wb_regwrite_r;
    wb_pc_4_s = wb_pc_4_r;  wb_alu_s = wb_alu_r;  wb_load_s = wb_load_r;
    wb_sel_s = wb_sel_r;  wb_rd_s = wb_rd_r;
    misalign_s = 1'b0;  bus_err_s = 1'b0;  stall_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (memop_s && !misaligned_s) begin
          stall_s = 1'b1;
          req_s   = 1'b1;
          we_s    = EXEC_MEMWRITE;
          addr_s  = EXEC_ALU_RESULT;
          wdata_s = align_wdata_s;
          be_s    = align_be_s;
          f3_s    = EXEC_FUNCT3;
          cnt_s   = 8'd0;
          state_s = ACCESS;
        end else begin
          wb_pc_4_s = EXEC_PC_4;  wb_alu_s = EXEC_ALU_RESULT;  wb_load_s = 32'd0;
          wb_sel_s  = EXEC_RF_WR_SEL;  wb_rd_s = EX_MS_RD;
          if (memop_s) begin
            wb_valid_s = 1'b1;  wb_regwrite_s = 1'b0;  misalign_s = 1'b1;
          end else begin
            wb_valid_s = EXEC_VALID;  wb_regwrite_s = EXEC_REGWRITE;
          end
        end
      end
      ACCESS: begin
        if (DMEM_ACK || cnt_r == CNT_LIMIT) begin
          req_s = 1'b0;  state_s = IDLE;  wb_valid_s = 1'b1;
          wb_pc_4_s = EXEC_PC_4;  wb_alu_s = EXEC_ALU_RESULT;
          wb_sel_s  = EXEC_RF_WR_SEL;  wb_rd_s = EX_MS_RD;
          if (DMEM_ACK) begin
            stall_s       = 1'b0;
            wb_regwrite_s = EXEC_REGWRITE;
            if (we_r) wb_load_s = 32'd0;
            else      wb_load_s = align_load_s;
          end else begin
            stall_s       = 1'b1;
            wb_regwrite_s = 1'b0;
            wb_load_s     = 32'd0;
            bus_err_s     = 1'b1;
          end
        end else begin
          stall_s = 1'b1;
          cnt_s   = cnt_r + 8'd1;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any access in flight.
  always_ff @(posedge MEMORY_CLOCK or negedge MEMORY_RESET_N) begin
    if (!MEMORY_RESET_N) begin
      state_r <= IDLE;  cnt_r <= 8'd0;  f3_r <= 3'd0;
      req_r <= 1'b0;  we_r <= 1'b0;  addr_r <= 32'd0;  wdata_r <= 32'd0;  be_r <= 4'd0;
      wb_valid_r <= 1'b0;  wb_regwrite_r <= 1'b0;  wb_pc_4_r <= 32'd0;
      wb_alu_r <= 32'd0;  wb_load_r <= 32'd0;  wb_sel_r <= 2'd0;  wb_rd_r <= 5'd0;
      misalign_r <= 1'b0;  bus_err_r <= 1'b0;
    end else begin
      state_r <= state_s;  cnt_r <= cnt_s;  f3_r <= f3_s;
      req_r <= req_s;  we_r <= we_s;  addr_r <= addr_s;  wdata_r <= wdata_s;  be_r <= be_s;
      wb_valid_r <= wb_valid_s;  wb_regwrite_r <= wb_regwrite_s;  wb_pc_4_r <= wb_pc_4_s;
      wb_alu_r <= wb_alu_s;  wb_load_r <= wb_load_s;  wb_sel_r <= wb_sel_s;  wb_rd_r <= wb_rd_s;
      misalign_r <= misalign_s;  bus_err_r <= bus_err_s;
    end
  end

  assign DMEM_REQ          = req_r;
  assign DMEM_WE           = we_r;
  assign DMEM_ADDR         = addr_r;
  assign DMEM_WDATA        = wdata_r;
  assign DMEM_BE           = be_r;
  assign MEM_STALL         = stall_s;
  assign MEM_WB_VALID      = wb_valid_r;
  assign MEM_WB_PC_4       = wb_pc_4_r;
  assign MEM_WB_ALU_RESULT = wb_alu_r;
  assign MEM_WB_LOAD_DATA  = wb_load_r;
  assign MEM_WB_RF_WR_SEL  = wb_sel_r;
  assign MEM_WB_REGWRITE   = wb_regwrite_r;
  assign MEM_WB_RD         = wb_rd_r;
  assign MISALIGN_ERR      = misalign_r;
  assign BUS_ERR           = bus_err_r;

endmodule

// File: tb/tb_memory_access_stage.sv
// Scoreboard bench for memory_access_stage: stimulus pushes expected MEM/WB
// retirements, a negedge monitor pops and compares them.
module tb_memory_access_stage;

  logic        MEMORY_CLOCK = 1'b0;
  logic        MEMORY_RESET_N = 1'b0;
  logic        EXEC_VALID, EXEC_REGWRITE, EXEC_MEMWRITE, EXEC_MEMREAD2, DMEM_ACK;
  logic [31:0] EXEC_PC_4, EXEC_ALU_RESULT, EXEC_RS2, DMEM_RDATA;
  logic [2:0]  EXEC_FUNCT3;
  logic [1:0]  EXEC_RF_WR_SEL;
  logic [4:0]  EX_MS_RD;
  logic        DMEM_REQ, DMEM_WE, MEM_STALL, MEM_WB_VALID, MEM_WB_REGWRITE, MISALIGN_ERR, BUS_ERR;
  logic [31:0] DMEM_ADDR, DMEM_WDATA, MEM_WB_PC_4, MEM_WB_ALU_RESULT, MEM_WB_LOAD_DATA;
  logic [3:0]  DMEM_BE;
  logic [1:0]  MEM_WB_RF_WR_SEL;
  logic [4:0]  MEM_WB_RD;

  memory_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .MEMORY_CLOCK(MEMORY_CLOCK), .MEMORY_RESET_N(MEMORY_RESET_N),
    .EXEC_VALID(EXEC_VALID), .EXEC_PC_4(EXEC_PC_4), .EXEC_ALU_RESULT(EXEC_ALU_RESULT),
    .EXEC_RS2(EXEC_RS2), .EXEC_FUNCT3(EXEC_FUNCT3), .EXEC_RF_WR_SEL(EXEC_RF_WR_SEL),
    .EXEC_REGWRITE(EXEC_REGWRITE), .EXEC_MEMWRITE(EXEC_MEMWRITE), .EXEC_MEMREAD2(EXEC_MEMREAD2),
    .EX_MS_RD(EX_MS_RD), .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR),
    .DMEM_WDATA(DMEM_WDATA), .DMEM_BE(DMEM_BE), .DMEM_ACK(DMEM_ACK), .DMEM_RDATA(DMEM_RDATA),
    .MEM_STALL(MEM_STALL), .MEM_WB_VALID(MEM_WB_VALID), .MEM_WB_PC_4(MEM_WB_PC_4),
    .MEM_WB_ALU_RESULT(MEM_WB_ALU_RESULT), .MEM_WB_LOAD_DATA(MEM_WB_LOAD_DATA),
    .MEM_WB_RF_WR_SEL(MEM_WB_RF_WR_SEL), .MEM_WB_REGWRITE(MEM_WB_REGWRITE),
    .MEM_WB_RD(MEM_WB_RD), .MISALIGN_ERR(MISALIGN_ERR), .BUS_ERR(BUS_ERR)
  );

  always #5 MEMORY_CLOCK = ~MEMORY_CLOCK;

  typedef struct packed {
    logic [31:0] pc_4;
    logic [31:0] alu;
    logic [31:0] load;
    logic [1:0]  sel;
    logic        regwrite;
    logic [4:0]  rd;
    logic        mis;
    logic        bus;
  } wb_t;

  wb_t exp_q[$];
  wb_t mon_act, mon_exp;
  int  n_checks = 0;
  int  n_pass = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every retirement must match the oldest expectation.
  always @(negedge MEMORY_CLOCK) begin
    if (MEMORY_RESET_N) begin
      if (MEM_WB_VALID) begin
        mon_act = {MEM_WB_PC_4, MEM_WB_ALU_RESULT, MEM_WB_LOAD_DATA, MEM_WB_RF_WR_SEL,
                   MEM_WB_REGWRITE, MEM_WB_RD, MISALIGN_ERR, BUS_ERR};
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL wb_unexpected: got retire %0h expected none", mon_act);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("wb_retire", 128'(mon_act), 128'(mon_exp));
        end
      end else if (MISALIGN_ERR || BUS_ERR) begin
        n_checks++;
        $display("FAIL err_without_retire: got mis=%b bus=%b expected 0 0", MISALIGN_ERR, BUS_ERR);
      end
    end
  end

  task automatic drive_idle();
    EXEC_VALID = 1'b0;  EXEC_MEMWRITE = 1'b0;  EXEC_MEMREAD2 = 1'b0;  EXEC_REGWRITE = 1'b0;
    EXEC_FUNCT3 = 3'd0;  EXEC_ALU_RESULT = 32'd0;  EXEC_RS2 = 32'd0;  EXEC_PC_4 = 32'd0;
    EXEC_RF_WR_SEL = 2'd0;  EX_MS_RD = 5'd0;
  endtask

  // Issue one instruction at posedge+1, hold it until it retires, ack after ack_after
  // access cycles with no ACK (large value = never ack).
  task automatic do_op(input int idx, input logic [31:0] pc4, input logic [31:0] alu,
                       input logic [31:0] rs2, input logic [2:0] f3, input logic wr,
                       input logic rd2, input logic regw, input logic [4:0] rd,
                       input int ack_after, input logic [31:0] rdata,
                       input int exp_stall, input int exp_req, input logic [3:0] exp_be,
                       input logic [31:0] exp_wdata, input logic [31:0] exp_load,
                       input logic exp_rw, input logic exp_mis, input logic exp_bus);
    int  stall_cnt, req_cnt;
    logic done, dmem_seen;
    logic [1:0] sel;
    sel = rd2 ? 2'd2 : 2'd3;
    EXEC_VALID = 1'b1;  EXEC_PC_4 = pc4;  EXEC_ALU_RESULT = alu;  EXEC_RS2 = rs2;
    EXEC_FUNCT3 = f3;  EXEC_MEMWRITE = wr;  EXEC_MEMREAD2 = rd2;  EXEC_REGWRITE = regw;
    EX_MS_RD = rd;  EXEC_RF_WR_SEL = sel;
    exp_q.push_back({pc4, alu, exp_load, sel, exp_rw, rd, exp_mis, exp_bus});
    stall_cnt = 0;  req_cnt = 0;  done = 1'b0;  dmem_seen = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      DMEM_ACK = (c == ack_after + 1);
      DMEM_RDATA = rdata;
      @(negedge MEMORY_CLOCK);
      if (MEM_STALL) stall_cnt++;
      if (DMEM_REQ) begin
        req_cnt++;
        if (!dmem_seen) begin
          dmem_seen = 1'b1;
          chk($sformatf("op%0d_dmem_we_addr_be_wdata", idx), {DMEM_WE, DMEM_ADDR, DMEM_BE, DMEM_WDATA},
              {wr, alu, exp_be, exp_wdata});
        end
      end
      @(posedge MEMORY_CLOCK); #1;
      if (MEM_WB_VALID) done = 1'b1;
    end
    DMEM_ACK = 1'b0;
    drive_idle();
    chk($sformatf("op%0d_retired", idx), 128'(done), 128'(1'b1));
    chk($sformatf("op%0d_stall_cycles", idx), 128'(stall_cnt), 128'(exp_stall));
    chk($sformatf("op%0d_req_cycles", idx), 128'(req_cnt), 128'(exp_req));
    chk($sformatf("op%0d_req_dropped", idx), 128'(DMEM_REQ), 128'(1'b0));
  endtask

  initial begin
    drive_idle();
    DMEM_ACK = 1'b0;  DMEM_RDATA = 32'd0;
    #12;
    chk("reset_outputs", {DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_WDATA, DMEM_BE, MEM_WB_VALID,
                          MEM_WB_PC_4, MEM_WB_ALU_RESULT, MEM_WB_LOAD_DATA, MEM_WB_RF_WR_SEL,
                          MEM_WB_REGWRITE, MEM_WB_RD, MISALIGN_ERR, BUS_ERR}, 128'd0);
    @(posedge MEMORY_CLOCK); #1;
    MEMORY_RESET_N = 1'b1;
    @(posedge MEMORY_CLOCK); #1;

    //    idx pc4           alu           rs2           f3      wr    rd2   regw  rd     ack  rdata         stall req be       wdata         load          rw    mis   bus
    do_op(1,  32'h104, 32'h1234, 32'h0,        3'b000, 1'b0, 1'b0, 1'b1, 5'd5,  100, 32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0);
    do_op(2,  32'h108, 32'h103,  32'hAB,       3'b000, 1'b1, 1'b0, 1'b0, 5'd0,  3,   32'h0,        4, 4, 4'b1000, 32'hABABABAB, 32'h0,        1'b0, 1'b0, 1'b0);
    do_op(3,  32'h10C, 32'h102,  32'h0,        3'b000, 1'b0, 1'b1, 1'b1, 5'd7,  1,   32'h0080FF00, 2, 2, 4'b0100, 32'h0,        32'hFFFFFF80, 1'b1, 1'b0, 1'b0);
    do_op(4,  32'h110, 32'h102,  32'h0,        3'b101, 1'b0, 1'b1, 1'b1, 5'd8,  0,   32'h0080FF00, 1, 1, 4'b1100, 32'h0,        32'h00000080, 1'b1, 1'b0, 1'b0);
    do_op(5,  32'h114, 32'h101,  32'h0,        3'b010, 1'b0, 1'b1, 1'b1, 5'd9,  100, 32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0);
    do_op(6,  32'h118, 32'h102,  32'h1234CDEF, 3'b001, 1'b1, 1'b0, 1'b0, 5'd0,  0,   32'h0,        1, 1, 4'b1100, 32'hCDEFCDEF, 32'h0,        1'b0, 1'b0, 1'b0);
    do_op(7,  32'h11C, 32'h100,  32'h0,        3'b001, 1'b0, 1'b1, 1'b1, 5'd10, 3,   32'h00008001, 4, 4, 4'b0011, 32'h0,        32'hFFFF8001, 1'b1, 1'b0, 1'b0);
    do_op(8,  32'h120, 32'h200,  32'h0,        3'b010, 1'b0, 1'b1, 1'b1, 5'd11, 100, 32'h0,        5, 4, 4'b1111, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1);
    do_op(9,  32'h124, 32'h300,  32'h11223344, 3'b010, 1'b1, 1'b1, 1'b1, 5'd12, 0,   32'hFFFFFFFF, 1, 1, 4'b1111, 32'h11223344, 32'h0,        1'b1, 1'b0, 1'b0);
    do_op(10, 32'h128, 32'h101,  32'h0,        3'b100, 1'b0, 1'b1, 1'b1, 5'd13, 0,   32'h0000F000, 1, 1, 4'b0010, 32'h0,        32'h000000F0, 1'b1, 1'b0, 1'b0);
    do_op(11, 32'h12C, 32'h204,  32'h0,        3'b010, 1'b0, 1'b1, 1'b1, 5'd14, 2,   32'hDEADBEEF, 3, 3, 4'b1111, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of an access; a late ACK must be ignored.
    EXEC_VALID = 1'b1;  EXEC_MEMREAD2 = 1'b1;  EXEC_REGWRITE = 1'b1;
    EXEC_FUNCT3 = 3'b010;  EXEC_ALU_RESULT = 32'h400;  EX_MS_RD = 5'd15;
    @(posedge MEMORY_CLOCK); #1;
    chk("req_before_reset", 128'(DMEM_REQ), 128'(1'b1));
    @(posedge MEMORY_CLOCK); #1;
    MEMORY_RESET_N = 1'b0;
    #1;
    chk("reset_mid_access_req_valid", {DMEM_REQ, MEM_WB_VALID}, 128'd0);
    drive_idle();
    @(posedge MEMORY_CLOCK); #1;
    MEMORY_RESET_N = 1'b1;
    DMEM_ACK = 1'b1;  DMEM_RDATA = 32'h12345678;
    @(negedge MEMORY_CLOCK);
    chk("late_ack_no_stall", 128'(MEM_STALL), 128'(1'b0));
    @(posedge MEMORY_CLOCK); #1;
    DMEM_ACK = 1'b0;
    chk("late_ack_ignored", {DMEM_REQ, MEM_WB_VALID, MISALIGN_ERR, BUS_ERR}, 128'd0);
    repeat (2) @(posedge MEMORY_CLOCK);
    #1;
    chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
